fifo_gather: RTL and testbench

Many-to-one counterpart of the FIFO replication stage: gathers several independent producer streams into one consumer stream. Each write channel owns a private FIFO; a round-robin arbiter drains them into a single read port. The read port tags every word with the index of its source channel. The block sits where parallel pipeline lanes (e.g. per-engine result writers) converge on one memory writer or one downstream consumer.

---
 rtl/fifo_gather_if.sv | 32 +++
 rtl/fifo_gather.sv | 127 ++++++++++++
 tb/tb_fifo_gather.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_gather_if.sv
// Bundled write/read/status signals of the many-to-one FIFO gather block.
// The master side drives writes and read requests; the slave side is the gather block.
interface fifo_gather_if #(
    parameter int WIDTH              = 8,
    parameter int LOG2_DEPTH         = 5,
    parameter int NUM_WRITE_CHANNELS = 3
);
    localparam int N     = NUM_WRITE_CHANNELS;
    localparam int CW    = LOG2_DEPTH + 1;
    localparam int SRC_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]       we;
    logic [N*WIDTH-1:0] wdata;
    logic [N-1:0]       almostfull;
    logic [N*CW-1:0]    count;
    logic [N-1:0]       overflow;
    logic               re;
    logic               rvalid;
    logic [WIDTH-1:0]   rdata;
    logic [SRC_W-1:0]   rsrc;
    logic               empty;

    modport master (
        output we, wdata, re,
        input  almostfull, count, overflow, rvalid, rdata, rsrc, empty
    );

    modport slave (
        input  we, wdata, re,
        output almostfull, count, overflow, rvalid, rdata, rsrc, empty
    );
endinterface

// File: rtl/fifo_gather.sv
// Per-channel FIFOs drained round-robin into one read port; each word is tagged with its source.
// Occupancy is the difference of CW-bit pointers, so it spans 0..DEPTH without an extra flag.
module fifo_gather #(
    parameter int WIDTH              = 8,
    parameter int LOG2_DEPTH         = 5,
    parameter int NUM_WRITE_CHANNELS = 3,
    parameter int ALMOSTFULL_MARGIN  = 4
) (
    input  logic          clk,
    input  logic          reset,
    fifo_gather_if.slave  bus
);
    localparam int N     = NUM_WRITE_CHANNELS;
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int CW    = LOG2_DEPTH + 1;
    localparam int SRC_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - ALMOSTFULL_MARGIN);

    logic [WIDTH-1:0] mem [N][DEPTH];
    logic [CW-1:0]    wr_ptr [N];
    logic [CW-1:0]    rd_ptr [N];
    logic [CW-1:0]    cnt    [N];

    logic [N-1:0]     ch_empty;
    logic [N-1:0]     ch_full;
    logic [N-1:0]     wr_ok;
    logic [N-1:0]     ovf_q;

    logic [SRC_W-1:0] last_grant;
    logic [SRC_W-1:0] grant;
    logic             grant_valid;

    logic             rvalid_q;
    logic [WIDTH-1:0] rdata_q;
    logic [SRC_W-1:0] rsrc_q;

    always_comb begin
        ch_empty = '0;
        ch_full  = '0;
        wr_ok    = '0;
        for (int i = 0; i < N; i++) begin
            cnt[i]      = wr_ptr[i] - rd_ptr[i];
            ch_empty[i] = (cnt[i] == '0);
            ch_full[i]  = (cnt[i] == FULL_CNT);
            wr_ok[i]    = bus.we[i] && !ch_full[i];
        end
    end

    always_comb begin
        bus.count      = '0;
        bus.almostfull = '0;
        for (int i = 0; i < N; i++) begin
            bus.count[i*CW +: CW] = cnt[i];
            bus.almostfull[i]     = (cnt[i] >= AF_LEVEL);
        end
    end

    assign bus.empty    = &ch_empty;
    assign bus.overflow = ovf_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rdata_q;
    assign bus.rsrc     = rsrc_q;

    // Search starts one past the last winner and wraps modulo N.
    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        grant = last_grant;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && !ch_empty[idx]) begin
                grant = SRC_W'(idx);
                found = 1'b1;
            end
        end
    end

    assign grant_valid = bus.re && !bus.empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            ovf_q      <= '0;
            last_grant <= SRC_W'(N - 1);
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rsrc_q     <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_ok[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (bus.we[i] && ch_full[i]) begin
                    ovf_q[i] <= 1'b1;
                end
                if (grant_valid && (int'(grant) == i)) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
            end
            rvalid_q <= grant_valid;
            if (grant_valid) begin
                rdata_q    <= mem[grant][rd_ptr[grant][LOG2_DEPTH-1:0]];
                rsrc_q     <= grant;
                last_grant <= grant;
            end
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (wr_ok[i]) begin
                mem[i][wr_ptr[i][LOG2_DEPTH-1:0]] <= bus.wdata[i*WIDTH +: WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_fifo_gather.sv
// Randomized and directed stimulus for fifo_gather, checked against a queue-based model.
// Expected read words go into a scoreboard queue that a negedge monitor consumes.
module tb_fifo_gather;
    localparam int WIDTH  = 8;
    localparam int LOG2_D = 5;
    localparam int N      = 3;
    localparam int MARGIN = 4;
    localparam int DEPTH  = 32;
    localparam int CW     = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fifo_gather_if #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_D), .NUM_WRITE_CHANNELS(N)) bus ();

    fifo_gather #(
        .WIDTH(WIDTH), .LOG2_DEPTH(LOG2_D),
        .NUM_WRITE_CHANNELS(N), .ALMOSTFULL_MARGIN(MARGIN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int mq [N][$];
    int exp_q [$];
    bit m_ovf [N];
    int m_lg = N - 1;
    bit exp_rvalid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            m_ovf[i] = 1'b0;
        end
        exp_q.delete();
        m_lg       = N - 1;
        exp_rvalid = 1'b0;
    endtask

    task automatic check_status();
        bit all_empty;
        all_empty = 1'b1;
        for (int i = 0; i < N; i++) begin
            check("count", 32'(bus.count[i*CW +: CW]), 32'(mq[i].size()));
            check("almostfull", 32'(bus.almostfull[i]), 32'(mq[i].size() >= DEPTH - MARGIN));
            check("overflow", 32'(bus.overflow[i]), 32'(m_ovf[i]));
            if (mq[i].size() != 0) all_empty = 1'b0;
        end
        check("empty", 32'(bus.empty), 32'(all_empty));
    endtask

    // One clock of stimulus; model applies the rules against pre-edge occupancy.
    task automatic step(input logic [N-1:0] we, input logic [N*WIDTH-1:0] wd, input logic re);
        bit acc [N];
        bit pend;
        bit found;
        int c;
        bus.we    = we;
        bus.wdata = wd;
        bus.re    = re;
        for (int i = 0; i < N; i++) begin
            acc[i] = we[i] && (mq[i].size() < DEPTH);
            if (we[i] && !acc[i]) m_ovf[i] = 1'b1;
        end
        pend  = 1'b0;
        found = 1'b0;
        if (re) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_lg + k) % N;
                if (!found && mq[c].size() > 0) begin
                    exp_q.push_back((c << WIDTH) | mq[c].pop_front());
                    m_lg  = c;
                    pend  = 1'b1;
                    found = 1'b1;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i]) mq[i].push_back(int'(wd[i*WIDTH +: WIDTH]));
        end
        @(posedge clk);
        exp_rvalid = pend;
        #1;
        check_status();
    endtask

    always @(negedge clk) begin
        int e;
        if (!reset) begin
            check("rvalid", 32'(bus.rvalid), 32'(exp_rvalid));
            if (bus.rvalid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_read: got %0h/%0d expected no word", bus.rdata, bus.rsrc);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", 32'(bus.rdata), 32'(e & 8'hFF));
                    check("rsrc", 32'(bus.rsrc), 32'(e >> WIDTH));
                end
            end
        end
    end

    initial begin
        logic [N*WIDTH-1:0] wd;
        logic [N-1:0]       wv;
        bus.we    = '0;
        bus.wdata = '0;
        bus.re    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_rsrc", 32'(bus.rsrc), 32'd0);
        check_status();
        reset = 1'b0;

        repeat (3) step('0, '0, 1'b1);

        // Round-robin order after reset starts at channel 0.
        step(3'b111, {8'hC0, 8'hB0, 8'hA0}, 1'b0);
        step(3'b101, {8'hC1, 8'h00, 8'hA1}, 1'b0);
        repeat (6) step('0, '0, 1'b1);
        step('0, '0, 1'b0);

        // Move last grant to 0, then only channel 2 holds data.
        step(3'b001, {16'h0, 8'h11}, 1'b0);
        step('0, '0, 1'b1);
        step(3'b100, {8'h55, 16'h0}, 1'b0);
        step('0, '0, 1'b1);
        step('0, '0, 1'b0);

        // Fill channel 1 past full, then drain it.
        for (int j = 0; j < DEPTH + 1; j++) begin
            wd = '0;
            wd[WIDTH +: WIDTH] = WIDTH'($urandom);
            step(3'b010, wd, 1'b0);
        end
        repeat (DEPTH + 1) step('0, '0, 1'b1);
        step('0, '0, 1'b0);

        // Full channel 0 with write and grant in the same cycle.
        for (int j = 0; j < DEPTH; j++) step(3'b001, {16'h0, 8'(j + 8'h40)}, 1'b0);
        step(3'b001, {16'h0, 8'hEE}, 1'b1);
        repeat (DEPTH) step('0, '0, 1'b1);
        step(3'b001, {16'h0, 8'h77}, 1'b1);
        step('0, '0, 1'b1);
        step('0, '0, 1'b0);

        // Random traffic, with bursts where reads are rare so FIFOs can fill.
        for (int j = 0; j < 600; j++) begin
            wd = N*WIDTH'({$urandom, $urandom});
            wv = N'($urandom);
            if (((j / 100) % 2) == 1) step(wv, wd, ($urandom_range(0, 7) == 0));
            else                      step(wv & N'($urandom), wd, ($urandom_range(0, 9) < 6));
        end
        repeat (3 * DEPTH + 2) step('0, '0, 1'b1);

        // Asynchronous reset while reads are in flight.
        for (int j = 0; j < 10; j++) begin
            wv = '0;
            wv[$urandom_range(0, N - 1)] = 1'b1;
            step(wv, N*WIDTH'({$urandom, $urandom}), 1'b0);
        end
        step('0, '0, 1'b1);
        step('0, '0, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_rvalid", 32'(bus.rvalid), 32'd0);
        model_reset();
        check_status();
        #1 reset = 1'b0;
        step(3'b110, {8'h92, 8'h91, 8'h00}, 1'b0);
        step(3'b001, {16'h0, 8'h90}, 1'b0);
        repeat (4) step('0, '0, 1'b1);
        step('0, '0, 1'b0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
